// File: rtl/ftdi_tx_framer_if.sv
// Byte-stream handshake bundle between the user source, the framer and the ftdi_245fifo send port.
// "it*" is the raw payload stream into the framer, "ot*" is the framed stream out of it.
interface ftdi_tx_framer_if;
    logic       itvalid;
    logic       itready;
    logic [7:0] itdata;
    logic       otvalid;
    logic       otready;
    logic [7:0] otdata;

    modport master (
        output itvalid, itdata, otready,
        input  itready, otvalid, otdata
    );

    modport slave (
        input  itvalid, itdata, otready,
        output itready, otvalid, otdata
    );
endinterface

// File: rtl/ftdi_tx_framer.sv
// Wraps a raw byte stream into frames: SYNC0 SYNC1 SEQ payload[PAYLOAD_LEN] CHK.
// CHK is the 8-bit sum of SEQ and the payload bytes; frames start only when payload is pending.
module ftdi_tx_framer #(
    parameter int         PAYLOAD_LEN = 256,
    parameter logic [7:0] SYNC0       = 8'hA5,
    parameter logic [7:0] SYNC1       = 8'h5A
) (
    input  logic                clk,
    input  logic                rst,
    ftdi_tx_framer_if.slave     s_if,
    output logic [15:0]         frame_cnt
);

    localparam int                 CNT_W    = $clog2(PAYLOAD_LEN + 1);
    localparam logic [CNT_W-1:0]   LAST_IDX = CNT_W'(PAYLOAD_LEN - 1);

    // States are named by the next byte to be loaded into the output register.
    typedef enum logic [2:0] {
        IDLE,
        S1,
        SEQ,
        PAY,
        CHK
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic             r_otvalid;
    logic             w_otvalid_nxt;
    logic [7:0]       r_otdata;
    logic [7:0]       w_otdata_nxt;
    logic [7:0]       r_seq;
    logic [7:0]       w_seq_nxt;
    logic [7:0]       r_sum;
    logic [7:0]       w_sum_nxt;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic             r_chk_out;
    logic             w_chk_out_nxt;
    logic [15:0]      r_frame_cnt;
    logic             w_slot_free;
    logic             w_itready;

    assign w_slot_free = !r_otvalid || s_if.otready;

    always_comb begin
        w_state_nxt   = r_state;
        w_otvalid_nxt = r_otvalid && !s_if.otready;
        w_otdata_nxt  = r_otdata;
        w_seq_nxt     = r_seq;
        w_sum_nxt     = r_sum;
        w_cnt_nxt     = r_cnt;
        w_chk_out_nxt = r_chk_out;
        w_itready     = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_slot_free && s_if.itvalid) begin
                    w_otvalid_nxt = 1'b1;
                    w_otdata_nxt  = SYNC0;
                    w_chk_out_nxt = 1'b0;
                    w_state_nxt   = S1;
                end
            end
            S1: begin
                if (w_slot_free) begin
                    w_otvalid_nxt = 1'b1;
                    w_otdata_nxt  = SYNC1;
                    w_chk_out_nxt = 1'b0;
                    w_state_nxt   = SEQ;
                end
            end
            SEQ: begin
                if (w_slot_free) begin
                    w_otvalid_nxt = 1'b1;
                    w_otdata_nxt  = r_seq;
                    w_sum_nxt     = r_seq;
                    w_chk_out_nxt = 1'b0;
                    w_state_nxt   = PAY;
                end
            end
            PAY: begin
                w_itready = w_slot_free;
                if (w_slot_free && s_if.itvalid) begin
                    w_otvalid_nxt = 1'b1;
                    w_otdata_nxt  = s_if.itdata;
                    w_sum_nxt     = r_sum + s_if.itdata;
                    w_cnt_nxt     = r_cnt + CNT_W'(1);
                    w_chk_out_nxt = 1'b0;
                    if (r_cnt == LAST_IDX) begin
                        w_state_nxt = CHK;
                    end
                end
            end
            CHK: begin
                if (w_slot_free) begin
                    w_otvalid_nxt = 1'b1;
                    w_otdata_nxt  = r_sum;
                    w_seq_nxt     = r_seq + 8'd1;
                    w_cnt_nxt     = '0;
                    w_chk_out_nxt = 1'b1;
                    w_state_nxt   = IDLE;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= IDLE;
            r_otvalid <= 1'b0;
            r_otdata  <= 8'h00;
            r_seq     <= 8'h00;
            r_sum     <= 8'h00;
            r_cnt     <= '0;
            r_chk_out <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_otvalid <= w_otvalid_nxt;
            r_otdata  <= w_otdata_nxt;
            r_seq     <= w_seq_nxt;
            r_sum     <= w_sum_nxt;
            r_cnt     <= w_cnt_nxt;
            r_chk_out <= w_chk_out_nxt;
        end
    end

    // A frame counts as emitted only once its CHK byte is taken downstream.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_frame_cnt <= 16'h0000;
        end else if (r_otvalid && s_if.otready && r_chk_out) begin
            r_frame_cnt <= r_frame_cnt + 16'd1;
        end
    end

    assign s_if.itready = w_itready;
    assign s_if.otvalid = r_otvalid;
    assign s_if.otdata  = r_otdata;
    assign frame_cnt    = r_frame_cnt;

endmodule
